// File: rtl/ser_stream_tx.sv
// Parameterised parallel-to-serial transmitter with a one-word pending buffer for gapless streaming.
// Optional feature macro: SER_PARITY_EN appends an even-parity cycle after each word.
module ser_stream_tx #(
    parameter int DATA_W    = 16,
    parameter int MOD_W     = $clog2(DATA_W),
    parameter int MIN_LEN   = 3,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              ser_par_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(MIN_LEN);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef SER_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd2;
`endif

    logic [1:0]        state, state_n;
    logic [DATA_W-1:0] sh_reg, sh_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] pend_data, pd_n;
    logic [CNT_W-1:0]  pend_cnt, pc_n;
    logic              pend_full, pf_n;
    logic              sd_n, sv_n, sp_n, busy_n;
    logic              par_acc, par_n;

    logic [CNT_W-1:0]  len_eff;
    logic              take, finish, out_bit;

    assign len_eff = (data_mod_i == '0) ? FULL_LEN : CNT_W'(data_mod_i);
    // Short words are silently dropped at acceptance; they never touch state.
    assign take    = data_val_i && !busy_o && (len_eff >= MIN_LEN_C);
    assign out_bit = MSB_FIRST ? sh_reg[DATA_W-1] : sh_reg[0];

    always_comb begin
        state_n = state;
        sh_n    = sh_reg;
        cnt_n   = cnt;
        pd_n    = pend_data;
        pc_n    = pend_cnt;
        pf_n    = pend_full;
        par_n   = par_acc;
        sd_n    = 1'b0;
        sv_n    = 1'b0;
        sp_n    = 1'b0;
        finish  = 1'b0;

        case (state)
            ST_SHIFT: begin
                sd_n  = out_bit;
                sv_n  = 1'b1;
                par_n = par_acc ^ out_bit;
                sh_n  = MSB_FIRST ? (sh_reg << 1) : (sh_reg >> 1);
                if (cnt == '0) begin
`ifdef SER_PARITY_EN
                    state_n = ST_PARITY;
`else
                    finish  = 1'b1;
`endif
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
`ifdef SER_PARITY_EN
            ST_PARITY: begin
                sd_n   = par_acc;
                sv_n   = 1'b1;
                sp_n   = 1'b1;
                finish = 1'b1;
            end
`endif
            default: ;
        endcase

        // Reload on the last cycle of a burst so the next word follows with no idle gap.
        if (finish) begin
            if (pend_full) begin
                state_n = ST_SHIFT;
                sh_n    = pend_data;
                cnt_n   = pend_cnt;
                par_n   = 1'b0;
                pf_n    = 1'b0;
            end else begin
                state_n = ST_IDLE;
            end
        end

        if (take) begin
            if (state_n == ST_IDLE) begin
                state_n = ST_SHIFT;
                sh_n    = data_i;
                cnt_n   = len_eff - 1'b1;
                par_n   = 1'b0;
            end else begin
                pd_n = data_i;
                pc_n = len_eff - 1'b1;
                pf_n = 1'b1;
            end
        end

        busy_n = (state_n != ST_IDLE) && pf_n;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state          <= ST_IDLE;
            sh_reg         <= '0;
            cnt            <= '0;
            pend_data      <= '0;
            pend_cnt       <= '0;
            pend_full      <= 1'b0;
            par_acc        <= 1'b0;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            ser_par_o      <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            state          <= state_n;
            sh_reg         <= sh_n;
            cnt            <= cnt_n;
            pend_data      <= pd_n;
            pend_cnt       <= pc_n;
            pend_full      <= pf_n;
            par_acc        <= par_n;
            ser_data_o     <= sd_n;
            ser_data_val_o <= sv_n;
            ser_par_o      <= sp_n;
            busy_o         <= busy_n;
        end
    end

endmodule

// File: tb/tb_ser_stream_tx.sv
// Directed bench for ser_stream_tx: one MSB-first and one LSB-first instance fed identical stimulus.
module tb_ser_stream_tx;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [15:0] data_i = '0;
    logic [3:0]  data_mod_i = '0;
    logic        data_val_i = 1'b0;

    logic m_sd, m_sv, m_sp, m_busy;
    logic l_sd, l_sv, l_sp, l_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ser_stream_tx #(.DATA_W(16), .MIN_LEN(3), .MSB_FIRST(1'b1)) u_msb (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .data_mod_i(data_mod_i),
        .data_val_i(data_val_i), .ser_data_o(m_sd), .ser_data_val_o(m_sv),
        .ser_par_o(m_sp), .busy_o(m_busy)
    );

    ser_stream_tx #(.DATA_W(16), .MIN_LEN(3), .MSB_FIRST(1'b0)) u_lsb (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .data_mod_i(data_mod_i),
        .data_val_i(data_val_i), .ser_data_o(l_sd), .ser_data_val_o(l_sv),
        .ser_par_o(l_sp), .busy_o(l_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Expected MSB-instance output word {val, data, par, busy}
    task automatic chk_m(input string tag, input logic v, input logic d, input logic p, input logic b);
        chk(tag, {28'd0, m_sv, m_sd, m_sp, m_busy}, {28'd0, v, d, p, b});
    endtask

    initial begin
        logic [3:0] t1_bits;
        logic [5:0] t3_bits;
        t1_bits = 4'b1010;
        t3_bits = 6'b101011;

        // Reset state
        #12;
        chk_m("reset_msb", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_lsb", {29'd0, l_sv, l_sd, l_busy}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();

        // 1: A5C3, 4 bits MSB first -> 1,0,1,0
        data_i = 16'hA5C3; data_mod_i = 4'd4; data_val_i = 1'b1;
        tick();
        data_val_i = 1'b0;
        chk_m("t1_latency", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_m($sformatf("t1_bit%0d", i), 1'b1, t1_bits[3-i], 1'b0, 1'b0);
        end
        tick();
        chk_m("t1_end", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // 2: 8001, mod 0 (16 bits), LSB first -> 1,0..0,1
        data_i = 16'h8001; data_mod_i = 4'd0; data_val_i = 1'b1;
        tick();
        data_val_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("t2_bit%0d", i), {30'd0, l_sv, l_sd},
                {30'd0, 1'b1, (i == 0 || i == 15)});
        end
        tick();
        chk("t2_end", {30'd0, l_sv, l_sd}, 32'd0);
        tick();

        // 3: back-to-back words, third offer while busy is ignored
        data_i = 16'hA000; data_mod_i = 4'd3; data_val_i = 1'b1;
        tick();
        chk_m("t3_acc0", 1'b0, 1'b0, 1'b0, 1'b0);
        data_i = 16'h6000;
        tick();
        chk_m("t3_b0", 1'b1, t3_bits[5], 1'b0, 1'b1);
        data_i = 16'hE000;
        tick();
        chk_m("t3_b1", 1'b1, t3_bits[4], 1'b0, 1'b1);
        data_val_i = 1'b0;
        for (int i = 2; i < 6; i++) begin
            tick();
            chk_m($sformatf("t3_b%0d", i), 1'b1, t3_bits[5-i], 1'b0, 1'b0);
        end
        tick();
        chk_m("t3_end", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_m("t3_no_third", 1'b0, 1'b0, 1'b0, 1'b0);

        // 4: length 2 is below the minimum and is dropped
        data_i = 16'hFFFF; data_mod_i = 4'd2; data_val_i = 1'b1;
        tick();
        data_val_i = 1'b0;
        chk_m("t4_c0", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_m("t4_c1", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_m("t4_c2", 1'b0, 1'b0, 1'b0, 1'b0);

        // 5: reset mid-burst with a pending word queued
        data_i = 16'hFFC0; data_mod_i = 4'd10; data_val_i = 1'b1;
        tick();
        data_i = 16'hFFFF; data_mod_i = 4'd3;
        tick();
        data_val_i = 1'b0;
        chk_m("t5_bit0", 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 5; i++) tick();
        chk_m("t5_bit4", 1'b1, 1'b1, 1'b0, 1'b1);
        rst_i = 1'b0;
        #1;
        chk_m("t5_async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_i = 1'b1;
        tick();
        chk_m("t5_pend_clr0", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_m("t5_pend_clr1", 1'b0, 1'b0, 1'b0, 1'b0);
        data_i = 16'h8000; data_mod_i = 4'd3; data_val_i = 1'b1;
        tick();
        data_val_i = 1'b0;
        tick();
        chk_m("t5_new_b0", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_m("t5_new_b1", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_m("t5_new_b2", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_m("t5_new_end", 1'b0, 1'b0, 1'b0, 1'b0);

        // 6: E000 mod 3 -> 1,1,1 (+ parity cycle when enabled)
        data_i = 16'hE000; data_mod_i = 4'd3; data_val_i = 1'b1;
        tick();
        data_val_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_m($sformatf("t6_bit%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        tick();
`ifdef SER_PARITY_EN
        chk_m("t6_parity", 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
`endif
        chk_m("t6_end", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
